regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write entries (power of two, at least 2).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 finish_flag  input  1  program finished; while high, no write is issued to the register file.
REQ-005 mem_valid  input  1  load/multi-cycle unit offers a result.
REQ-006 mem_rd  input  5  destination register of the mem result.
REQ-007 mem_data  input  32  mem result value.
REQ-008 mem_ready  output  1  mem result accepted this cycle when high together with mem_valid.
REQ-009 alu_valid  input  1  ALU offers a result.
REQ-010 alu_rd  input  5  destination register of the ALU result.
REQ-011 alu_data  input  32  ALU result value.
REQ-012 alu_ready  output  1  ALU result accepted this cycle when high together with alu_valid.
REQ-013 RD  output  5  register-file write address (head entry).
REQ-014 WriteData  output  32  register-file write data (head entry).
REQ-015 RegWrite  output  1  register-file write enable.
REQ-016 pending_mask  output  32  bit i high when some queued entry targets register i.
REQ-017 commit_count  output  16  number of writes issued since reset, saturating.

Function
REQ-018 The block SHALL hold an in-order FIFO of DEPTH {rd, data} entries, with a count from 0 to DEPTH.
REQ-019 At most one enqueue per cycle; mem has priority over alu.
REQ-020 mem_ready = not full; alu_ready = not full AND NOT mem_valid; both depend only on the current count and mem_valid.
REQ-021 An accepted handshake with rd == 0 SHALL complete without storing an entry (writes to x0 are dropped).
REQ-022 An accepted handshake with rd != 0 SHALL be written at the tail on that rising edge.
REQ-023 RegWrite = (count != 0) AND NOT finish_flag; RD and WriteData SHALL be the head entry combinationally, and 0 when the FIFO is empty.
REQ-024 When RegWrite is high, the head SHALL be popped on the same rising edge, so the register file and the pop both act on that edge.
REQ-025 Latency: a result accepted on edge N SHALL appear with RegWrite high in the cycle after edge N when the FIFO was empty and finish_flag is low.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; when full, no push is accepted even if a pop occurs that cycle (no pass-through).
REQ-027 While finish_flag is high: pops stall, entries are retained, and handshakes continue while not full; draining resumes the cycle after finish_flag falls.
REQ-028 pending_mask SHALL be the OR of one-hot decodes of all valid entries' rd, combinational from FIFO state; bit 0 is always 0.
REQ-029 commit_count SHALL increment on each edge where RegWrite is high, and hold at 16'hFFFF.
REQ-030 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 On reset high at an edge: count, pointers and commit_count SHALL become 0, so RegWrite=0, RD=0, WriteData=0, pending_mask=0, mem_ready=1, and alu_ready=NOT mem_valid.
REQ-032 Reset SHALL discard queued entries mid-operation; a handshake in the reset cycle is not stored.
REQ-033 Storage arrays need no reset.

Structure
REQ-034 A shared package SHALL hold constants XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the entry record type {rd, data}.
REQ-035 The FIFO SHALL be one sub-module, wb_fifo (push/pop/full/empty/count, plus an entries view used for pending_mask).

Verification
REQ-036 Single ALU write: alu_valid=1, alu_rd=5, alu_data=7 for one cycle -> next cycle RegWrite=1, RD=5, WriteData=7, pending_mask=32'h20; then RegWrite=0 and commit_count=1.
REQ-037 Collision: mem (rd=3, data=9) and alu (rd=4, data=1) valid together -> mem accepted first, alu_ready=0 that cycle; alu accepted the next cycle; writes appear in order x3 then x4.
REQ-038 x0 drop: mem_valid with rd=0 and data=32'hDEAD -> mem_ready=1, no RegWrite, pending_mask=0, commit_count unchanged.
REQ-039 Full: hold finish_flag=1 and push 4 entries -> mem_ready=0 and alu_ready=0, RegWrite=0; drop finish_flag -> 4 consecutive writes in order, then ready returns.
REQ-040 Reset mid-drain: 3 entries queued, reset pulses for one cycle -> RegWrite=0, pending_mask=0 and commit_count=0 the following cycle; the queued entries are never written.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file writeback block.
//   XLEN, REG_ADDR_W, NUM_REGS : datapath / register-file geometry
//   wb_entry_t                 : one queued write {rd, data}
//   rd_onehot()                : one-hot decode of a destination register
package regfile_writeback_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Result-offer bus between the producing units (mem, ALU) and the writeback block.
//   mem_valid/mem_rd/mem_data -> mem_ready : load / multi-cycle unit channel
//   alu_valid/alu_rd/alu_data -> alu_ready : ALU channel
// master = producer side, slave = writeback side.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_ready;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_ready;

  modport master (
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO of pending register writes.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_push, i_push_entry: enqueue at tail (ignored when full)
//   i_pop               : dequeue head (ignored when empty)
//   o_head              : head entry (storage contents; caller masks when empty)
//   o_full, o_empty     : occupancy flags
//   o_count             : occupancy 0..DEPTH
//   o_entries, o_valid  : raw storage view and per-slot occupancy
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output wb_entry_t [DEPTH-1:0]      o_entries,
  output logic [DEPTH-1:0]           o_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_off;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    o_valid = '0;
    w_off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - r_rd_ptr;
      o_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_entries = r_mem;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback stage: arbitrates mem/ALU results into an in-order
// queue and drains one write per cycle into the register file.
//   clock, reset  : clock, synchronous active-high reset
//   finish_flag   : stalls draining while high
//   wb_bus        : mem / ALU result handshakes (slave side)
//   RD, WriteData, RegWrite : register-file write port (head of queue)
//   pending_mask  : registers with a queued write
//   commit_count  : saturating count of issued writes
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  finish_flag,
  regfile_writeback_if.slave    wb_bus,
  output logic [REG_ADDR_W-1:0] RD,
  output logic [XLEN-1:0]       WriteData,
  output logic                  RegWrite,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [15:0]           commit_count
);

  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_mem_fire;
  logic                  w_alu_fire;
  logic                  w_push;
  logic [15:0]           r_commit_count;

  // Mem wins arbitration; the ALU only sees ready when mem is idle.
  assign wb_bus.mem_ready = !w_full;
  assign wb_bus.alu_ready = !w_full && !wb_bus.mem_valid;

  assign w_mem_fire = wb_bus.mem_valid && wb_bus.mem_ready;
  assign w_alu_fire = wb_bus.alu_valid && wb_bus.alu_ready;

  // Writes to x0 complete the handshake but are never queued.
  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (w_mem_fire) begin
      w_push       = (wb_bus.mem_rd != '0);
      w_push_entry = '{rd: wb_bus.mem_rd, data: wb_bus.mem_data};
    end else if (w_alu_fire) begin
      w_push       = (wb_bus.alu_rd != '0);
      w_push_entry = '{rd: wb_bus.alu_rd, data: wb_bus.alu_data};
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (RegWrite),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_entries    (w_entries),
    .o_valid      (w_valid)
  );

  assign RegWrite  = (w_count != '0) && !finish_flag;
  assign RD        = w_empty ? '0 : w_head.rd;
  assign WriteData = w_empty ? '0 : w_head.data;

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) pending_mask = pending_mask | rd_onehot(w_entries[i].rd);
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_commit_count <= '0;
    end else if (RegWrite && (r_commit_count != 16'hFFFF)) begin
      r_commit_count <= r_commit_count + 16'd1;
    end
  end

  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clock;
  logic        reset;
  logic        finish_flag;
  logic [4:0]  RD;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] pending_mask;
  logic [15:0] commit_count;

  int n_vec;
  int n_err;

  regfile_writeback_if bus ();

  regfile_writeback #(
    .DEPTH (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .finish_flag  (finish_flag),
    .wb_bus       (bus),
    .RD           (RD),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .pending_mask (pending_mask),
    .commit_count (commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    finish_flag = 1'b0;
    idle_inputs();
    tick();
    // Handshake offered while reset is high must not be stored.
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'h1234;
    #1;
    n_vec++;
    if (bus.mem_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mem_ready got %0b want 1", bus.mem_ready);
    end
    n_vec++;
    if (bus.alu_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_alu_ready_memvalid got %0b want 0", bus.alu_ready);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_vec++;
    if (RegWrite !== 1'b0) begin
      n_err++; $display("FAIL reset_regwrite got %0b want 0", RegWrite);
    end
    n_vec++;
    if (RD !== 5'd0 || WriteData !== 32'd0) begin
      n_err++; $display("FAIL reset_rd_wd got %0d/%0h want 0/0", RD, WriteData);
    end
    n_vec++;
    if (pending_mask !== 32'd0) begin
      n_err++; $display("FAIL reset_pending got %0h want 0", pending_mask);
    end
    n_vec++;
    if (commit_count !== 16'd0) begin
      n_err++; $display("FAIL reset_commit got %0d want 0", commit_count);
    end
    n_vec++;
    if (bus.alu_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_alu_ready got %0b want 1", bus.alu_ready);
    end
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'd7;
    #1;
    n_vec++;
    if (bus.alu_ready !== 1'b1) begin
      n_err++; $display("FAIL alu_ready got %0b want 1", bus.alu_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 32'd7) begin
      n_err++;
      $display("FAIL alu_write got we=%0b rd=%0d wd=%0h want 1/5/7", RegWrite, RD, WriteData);
    end
    n_vec++;
    if (pending_mask !== 32'h20) begin
      n_err++; $display("FAIL alu_pending got %0h want 20", pending_mask);
    end
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || commit_count !== 16'd1) begin
      n_err++; $display("FAIL alu_after got we=%0b cc=%0d want 0/1", RegWrite, commit_count);
    end
  endtask

  task automatic test_collision();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd3;
    bus.mem_data  = 32'd9;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 32'd1;
    #1;
    n_vec++;
    if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL coll_ready got mem=%0b alu=%0b want 1/0", bus.mem_ready, bus.alu_ready);
    end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.alu_ready !== 1'b1) begin
      n_err++; $display("FAIL coll_alu_ready2 got %0b want 1", bus.alu_ready);
    end
    n_vec++;
    if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 32'd9 || pending_mask !== 32'h8) begin
      n_err++;
      $display("FAIL coll_first got we=%0b rd=%0d wd=%0h pm=%0h want 1/3/9/8",
               RegWrite, RD, WriteData, pending_mask);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (RegWrite !== 1'b1 || RD !== 5'd4 || WriteData !== 32'd1 || pending_mask !== 32'h10) begin
      n_err++;
      $display("FAIL coll_second got we=%0b rd=%0d wd=%0h pm=%0h want 1/4/1/10",
               RegWrite, RD, WriteData, pending_mask);
    end
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || commit_count !== 16'd3) begin
      n_err++; $display("FAIL coll_after got we=%0b cc=%0d want 0/3", RegWrite, commit_count);
    end
  endtask

  task automatic test_x0_drop();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'hDEAD;
    #1;
    n_vec++;
    if (bus.mem_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_ready got %0b want 1", bus.mem_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (RegWrite !== 1'b0 || pending_mask !== 32'd0 || commit_count !== 16'd3) begin
      n_err++;
      $display("FAIL x0_drop got we=%0b pm=%0h cc=%0d want 0/0/3",
               RegWrite, pending_mask, commit_count);
    end
  endtask

  task automatic test_full();
    finish_flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(10 + i);
      bus.mem_data  = 32'(100 + i);
      tick();
    end
    // Keep offering while full: must not be accepted.
    bus.mem_rd   = 5'd14;
    bus.mem_data = 32'h200;
    #1;
    n_vec++;
    if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready got mem=%0b alu=%0b want 0/0", bus.mem_ready, bus.alu_ready);
    end
    n_vec++;
    if (RegWrite !== 1'b0 || pending_mask !== 32'h3C00) begin
      n_err++;
      $display("FAIL full_hold got we=%0b pm=%0h want 0/3c00", RegWrite, pending_mask);
    end
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || commit_count !== 16'd3 || pending_mask !== 32'h3C00) begin
      n_err++;
      $display("FAIL full_stall got we=%0b cc=%0d pm=%0h want 0/3/3c00",
               RegWrite, commit_count, pending_mask);
    end
    idle_inputs();
    finish_flag = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (RegWrite !== 1'b1 || RD !== 5'(10 + i) || WriteData !== 32'(100 + i)) begin
        n_err++;
        $display("FAIL full_drain%0d got we=%0b rd=%0d wd=%0d want 1/%0d/%0d",
                 i, RegWrite, RD, WriteData, 10 + i, 100 + i);
      end
      tick();
    end
    n_vec++;
    if (RegWrite !== 1'b0 || bus.mem_ready !== 1'b1 || commit_count !== 16'd7
        || pending_mask !== 32'd0) begin
      n_err++;
      $display("FAIL full_after got we=%0b rdy=%0b cc=%0d pm=%0h want 0/1/7/0",
               RegWrite, bus.mem_ready, commit_count, pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    bus.alu_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.alu_rd   = 5'(20 + i);
      bus.alu_data = 32'(500 + i);
      tick();
      n_vec++;
      if (RegWrite !== 1'b1 || RD !== 5'(20 + i) || WriteData !== 32'(500 + i)
          || pending_mask !== (32'd1 << (20 + i))) begin
        n_err++;
        $display("FAIL b2b%0d got we=%0b rd=%0d wd=%0d pm=%0h want rd=%0d wd=%0d",
                 i, RegWrite, RD, WriteData, pending_mask, 20 + i, 500 + i);
      end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || commit_count !== 16'd12) begin
      n_err++; $display("FAIL b2b_after got we=%0b cc=%0d want 0/12", RegWrite, commit_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    finish_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(1 + i);
      bus.alu_data  = 32'(40 + i);
      tick();
    end
    idle_inputs();
    finish_flag = 1'b0;
    #1;
    n_vec++;
    if (RegWrite !== 1'b1 || RD !== 5'd1 || pending_mask !== 32'hE) begin
      n_err++;
      $display("FAIL mid_pre got we=%0b rd=%0d pm=%0h want 1/1/e", RegWrite, RD, pending_mask);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (RegWrite !== 1'b0 || pending_mask !== 32'd0 || commit_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset got we=%0b pm=%0h cc=%0d want 0/0/0",
               RegWrite, pending_mask, commit_count);
    end
    tick();
    n_vec++;
    if (RegWrite !== 1'b0 || commit_count !== 16'd0 || RD !== 5'd0) begin
      n_err++;
      $display("FAIL mid_never got we=%0b cc=%0d rd=%0d want 0/0/0", RegWrite, commit_count, RD);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_alu();
    test_collision();
    test_x0_drop();
    test_full();
    test_back_to_back();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
